alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits (legal range 8..64).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-006 SHALL have port in_a, in_b  input  WIDTH each  signed operands.
REQ-007 SHALL have port in_op  input  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-008 SHALL have port in_set_cc  input  1  request updates condition codes.
REQ-009 SHALL have port out_valid  output  1  result register holds an undelivered result.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-011 SHALL have port out_ans  output  WIDTH  registered signed result.
REQ-012 SHALL have port out_overflow  output  1  registered signed-overflow flag of that result.
REQ-013 SHALL have port cc  output  3  condition-code register {ZF,SF,OF}.
REQ-014 SHALL have port cond_fn  input  3  condition select: 0 always, 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, 7 reserved.
REQ-015 SHALL have port cnd  output  1  condition evaluated on current cc.

Function
REQ-016 SHALL compute ADD a+b, SUB a-b, AND a&b, XOR a^b, all modulo 2^WIDTH.
REQ-017 SHALL set overflow for ADD when a,b signs equal and result sign differs from a; for SUB when a,b signs differ and result sign differs from a; 0 for AND/XOR.
REQ-018 SHALL accept a request on a cycle where in_valid && in_ready; in_ready = !out_valid || out_ready (combinational).
REQ-019 SHALL load out_ans/out_overflow and set out_valid on the edge after acceptance: latency exactly 1 cycle.
REQ-020 SHALL hold out_ans, out_overflow, out_valid stable while out_valid && !out_ready.
REQ-021 SHALL clear out_valid on out_ready when no new request is accepted the same cycle; on simultaneous drain and accept SHALL load the new result with out_valid staying 1 (full throughput, one result per cycle).
REQ-022 SHALL update cc on the acceptance edge only if in_set_cc: ZF = (result==0), SF = result[WIDTH-1], OF = overflow; otherwise cc holds.
REQ-023 SHALL evaluate cnd combinationally from current cc: le (SF^OF)|ZF, l SF^OF, e ZF, ne !ZF, ge !(SF^OF), g !(SF^OF)&!ZF, always 1, reserved 0.
REQ-024 SHALL let cnd in the cycle after an accepted in_set_cc request reflect the new cc (no bypass in the accept cycle itself).
REQ-025 SHALL ignore in_a/in_b/in_op/in_set_cc when no acceptance occurs.

Reset
REQ-026 SHALL on rst: out_valid=0, out_ans=0, out_overflow=0, cc=3'b100 (ZF=1, SF=0, OF=0).
REQ-027 SHALL give rst priority over any same-cycle acceptance; a request presented with rst high is discarded and cc unchanged from reset value.
REQ-028 SHALL drive in_ready=1 during and immediately after reset.

Structure
REQ-029 SHALL place op encodings, cond_fn encodings and CC bit indices in shared package alu_pkg.
REQ-030 SHALL instantiate one combinational sub-module alu_core (WIDTH-parametrised; result and overflow) feeding the registered stage.

Verification
REQ-031 SHALL cover: WIDTH=64, ADD 0x7FFFFFFFFFFFFFFF+1, set_cc=1 -> next cycle out_ans=0x8000000000000000, out_overflow=1, cc={0,1,1}, cnd(l)=0, cnd(le)=0.
REQ-032 SHALL cover: SUB 5-5 set_cc=1 -> out_ans=0, cc={1,0,0}; cond_fn=3 -> cnd=1, cond_fn=6 -> cnd=0.
REQ-033 SHALL cover: out_ready=0 for 3 cycles after result 0xA -> out_ans held 0xA, in_ready=0, second request not accepted until out_ready=1.
REQ-034 SHALL cover: back-to-back XOR 0xF0^0x0F then AND 0xF0&0x0F with out_ready=1 -> out_ans 0xFF then 0x0 on consecutive cycles, out_valid continuously 1.
REQ-035 SHALL cover: AND with set_cc=0 after cc={0,1,1} -> cc unchanged; rst asserted mid-stall -> out_valid=0, cc=3'b100 next cycle.
REQ-036 SHALL cover: WIDTH=8, SUB 0x80-0x01 -> out_ans=0x7F, out_overflow=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: operation and condition
// encodings, condition-code bit positions, and the condition evaluator.
package alu_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_XOR = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      COND_ALWAYS = 3'd0,
      COND_LE     = 3'd1,
      COND_L      = 3'd2,
      COND_E      = 3'd3,
      COND_NE     = 3'd4,
      COND_GE     = 3'd5,
      COND_G      = 3'd6,
      COND_RSVD   = 3'd7
   } cond_fn_e;

   // Condition-code register layout: {ZF, SF, OF}
   localparam int CC_ZF = 2;
   localparam int CC_SF = 1;
   localparam int CC_OF = 0;

   // After reset the flags describe a zero result with no overflow.
   localparam logic [2:0] CC_RESET = 3'b100;

   // Evaluate a branch-style condition on a condition-code value.
   function automatic logic eval_cond(input logic [2:0] cc_v, input logic [2:0] fn);
      logic zf;
      logic lt;
      zf = cc_v[CC_ZF];
      lt = cc_v[CC_SF] ^ cc_v[CC_OF];
      case (cond_fn_e'(fn))
         COND_ALWAYS: eval_cond = 1'b1;
         COND_LE:     eval_cond = lt | zf;
         COND_L:      eval_cond = lt;
         COND_E:      eval_cond = zf;
         COND_NE:     eval_cond = !zf;
         COND_GE:     eval_cond = !lt;
         COND_G:      eval_cond = !lt & !zf;
         default:     eval_cond = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and signed-overflow flag.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             overflow
);

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;

   assign sum  = a + b;
   assign diff = a - b;

   // Select the operation; overflow compares operand and result signs.
   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alu_op_e'(op))
         OP_ADD: begin
            result   = sum;
            overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            result   = diff;
            overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: result = a & b;
         OP_XOR: result = a ^ b;
         default: begin
            result   = '0;
            overflow = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage registered ALU with valid/ready handshakes on both sides
// and a condition-code register that can be updated per request.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The producer holds its payload stable while valid && !ready; the
// result side holds out_ans/out_overflow/out_valid until out_ready.
// in_ready is combinational so a drain and a new accept can share a
// cycle, giving one result per cycle.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_op,
   input  logic             in_set_cc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_ans,
   output logic             out_overflow,
   output logic [2:0]       cc,
   input  logic [2:0]       cond_fn,
   output logic             cnd
);

   logic [WIDTH-1:0] core_result;
   logic             core_overflow;
   logic             accept;

   alu_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a        (in_a),
      .b        (in_b),
      .op       (in_op),
      .result   (core_result),
      .overflow (core_overflow)
   );

   // Ready whenever the result slot is empty or being drained; also forced
   // high during reset so upstream never sees a stall across reset.
   assign in_ready = rst || !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !rst;

   // Result register: load on accept, otherwise drain on out_ready.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_ans      <= '0;
         out_overflow <= 1'b0;
      end else if (accept) begin
         out_valid    <= 1'b1;
         out_ans      <= core_result;
         out_overflow <= core_overflow;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // Condition codes change only on an accepted request that asks for it.
   always_ff @(posedge clk) begin
      if (rst) begin
         cc <= CC_RESET;
      end else if (accept && in_set_cc) begin
         cc[CC_ZF] <= (core_result == '0);
         cc[CC_SF] <= core_result[WIDTH-1];
         cc[CC_OF] <= core_overflow;
      end
   end

   // Condition is read from the registered flags; no same-cycle bypass.
   always_comb begin
      cnd = eval_cond(cc, cond_fn);
   end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: table vectors, directed corner
// sequences, and randomized traffic against a queue-based reference.
module tb_alu_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_a = '0;
   logic [63:0] in_b = '0;
   logic [1:0]  in_op = '0;
   logic        in_set_cc = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_ans;
   logic        out_overflow;
   logic [2:0]  cc;
   logic [2:0]  cond_fn = '0;
   logic        cnd;

   // 8-bit instance for narrow-width boundary checks
   logic        n_in_valid = 1'b0;
   logic        n_in_ready;
   logic [7:0]  n_in_a = '0;
   logic [7:0]  n_in_b = '0;
   logic [1:0]  n_in_op = '0;
   logic        n_out_valid;
   logic [7:0]  n_out_ans;
   logic        n_out_overflow;
   logic [2:0]  n_cc;
   logic        n_cnd;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: pending result queue {ovf, ans} and flag register
   logic [64:0] exp_q[$];
   logic [2:0]  m_cc = 3'b100;
   bit          model_live = 1'b0;

   alu_pipe #(.WIDTH(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_set_cc(in_set_cc),
      .out_valid(out_valid), .out_ready(out_ready), .out_ans(out_ans),
      .out_overflow(out_overflow), .cc(cc), .cond_fn(cond_fn), .cnd(cnd)
   );

   alu_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .in_a(n_in_a), .in_b(n_in_b), .in_op(n_in_op), .in_set_cc(1'b1),
      .out_valid(n_out_valid), .out_ready(1'b1), .out_ans(n_out_ans),
      .out_overflow(n_out_overflow), .cc(n_cc), .cond_fn(3'd0), .cnd(n_cnd)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Arithmetic reference: exact signed math, overflow = out of range.
   function automatic logic [64:0] ref_calc(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b, input int w);
      logic signed [65:0] sa, sb, s, max_v, min_v, lim;
      logic [65:0]        mask;
      logic [63:0]        am, bm, ans;
      logic               ovf;
      mask  = (66'd1 << w) - 66'd1;
      am    = a & mask[63:0];
      bm    = b & mask[63:0];
      lim   = 66'sd1 <<< (w - 1);
      max_v = lim - 66'sd1;
      min_v = -lim;
      sa    = am[w-1] ? $signed({2'b00, am} - (66'd1 << w)) : $signed({2'b00, am});
      sb    = bm[w-1] ? $signed({2'b00, bm} - (66'd1 << w)) : $signed({2'b00, bm});
      ovf   = 1'b0;
      case (op)
         2'b00: begin s = sa + sb; ovf = (s > max_v) || (s < min_v); ans = s[63:0]; end
         2'b01: begin s = sa - sb; ovf = (s > max_v) || (s < min_v); ans = s[63:0]; end
         2'b10: ans = am & bm;
         default: ans = am ^ bm;
      endcase
      ref_calc = {ovf, ans & mask[63:0]};
   endfunction

   function automatic logic ref_cnd(input logic [2:0] f, input logic [2:0] fn);
      logic zf, sf, of;
      {zf, sf, of} = f;
      case (fn)
         3'd0: ref_cnd = 1'b1;
         3'd1: ref_cnd = (sf != of) || zf;
         3'd2: ref_cnd = (sf != of);
         3'd3: ref_cnd = zf;
         3'd4: ref_cnd = !zf;
         3'd5: ref_cnd = (sf == of);
         3'd6: ref_cnd = (sf == of) && !zf;
         default: ref_cnd = 1'b0;
      endcase
   endfunction

   task automatic check_all();
      chk("in_ready", in_ready, rst || exp_q.size() == 0 || out_ready);
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
         chk("out_ans", out_ans, exp_q[0][63:0]);
         chk("out_overflow", out_overflow, exp_q[0][64]);
      end
      chk("cc", cc, m_cc);
      chk("cnd", cnd, ref_cnd(m_cc, cond_fn));
   endtask

   task automatic model_advance();
      logic [64:0] r;
      bit          acc;
      if (rst) begin
         exp_q.delete();
         m_cc = 3'b100;
      end else begin
         acc = in_valid && (exp_q.size() == 0 || out_ready);
         if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
         if (acc) begin
            r = ref_calc(in_op, in_a, in_b, 64);
            exp_q.push_back(r);
            if (in_set_cc) m_cc = {r[63:0] == 64'd0, r[63], r[64]};
         end
      end
   endtask

   // One clock: check mid-cycle, advance the model, land #1 past the edge.
   task automatic step();
      @(negedge clk);
      if (model_live) check_all();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic sc);
      in_valid  = v;
      in_op     = op;
      in_a      = a;
      in_b      = b;
      in_set_cc = sc;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [63:0] a, b, ans;
      logic        ovf;
   } vec64_t;

   typedef struct {
      logic [1:0] op;
      logic [7:0] a, b, ans;
      logic       ovf;
   } vec8_t;

   localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

   initial begin
      vec64_t t64[8];
      vec8_t  t8[8];

      t64[0] = '{2'b00, 64'd1, 64'd2, 64'd3, 1'b0};
      t64[1] = '{2'b00, MAXP, 64'd1, MINN, 1'b1};
      t64[2] = '{2'b00, MINN, MINN, 64'd0, 1'b1};
      t64[3] = '{2'b01, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
      t64[4] = '{2'b01, MINN, 64'd1, MAXP, 1'b1};
      t64[5] = '{2'b01, MAXP, 64'hFFFF_FFFF_FFFF_FFFF, MINN, 1'b1};
      t64[6] = '{2'b10, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0,
                 64'h0F00_0F00_0F00_0F00, 1'b0};
      t64[7] = '{2'b11, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0,
                 64'hF0F0_F0F0_F0F0_F0F0, 1'b0};

      t8[0] = '{2'b01, 8'h80, 8'h01, 8'h7F, 1'b1};
      t8[1] = '{2'b00, 8'h7F, 8'h01, 8'h80, 1'b1};
      t8[2] = '{2'b00, 8'hFF, 8'h01, 8'h00, 1'b0};
      t8[3] = '{2'b01, 8'h00, 8'h80, 8'h80, 1'b1};
      t8[4] = '{2'b01, 8'h7F, 8'hFF, 8'h80, 1'b1};
      t8[5] = '{2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0};
      t8[6] = '{2'b11, 8'hF0, 8'h3C, 8'hCC, 1'b0};
      t8[7] = '{2'b00, 8'h80, 8'hFF, 8'h7F, 1'b1};

      // Reset
      rst = 1'b1;
      step();
      model_live = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_ans", out_ans, 64'd0);
      chk("rst_out_overflow", out_overflow, 1'b0);
      chk("rst_cc", cc, 3'b100);
      chk("rst_in_ready", in_ready, 1'b1);

      // Table vectors, one per cycle at full throughput
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, t64[i].op, t64[i].a, t64[i].b, 1'b1);
         step();
         chk($sformatf("tbl64_%0d_ans", i), out_ans, t64[i].ans);
         chk($sformatf("tbl64_%0d_ovf", i), out_overflow, t64[i].ovf);
         chk($sformatf("tbl64_%0d_valid", i), out_valid, 1'b1);
      end
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      step();

      // Positive overflow sets SF and OF; l and le both false
      cond_fn = 3'd2;
      drive(1'b1, 2'b00, MAXP, 64'd1, 1'b1);
      step();
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      chk("ovf_ans", out_ans, MINN);
      chk("ovf_flag", out_overflow, 1'b1);
      chk("ovf_cc", cc, 3'b011);
      chk("ovf_cnd_l", cnd, 1'b0);
      cond_fn = 3'd1;
      #1;
      chk("ovf_cnd_le", cnd, 1'b0);

      // Equal subtraction gives zero flags
      drive(1'b1, 2'b01, 64'd5, 64'd5, 1'b1);
      step();
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      chk("sub_eq_ans", out_ans, 64'd0);
      chk("sub_eq_cc", cc, 3'b100);
      cond_fn = 3'd3;
      #1;
      chk("sub_eq_cnd_e", cnd, 1'b1);
      cond_fn = 3'd6;
      #1;
      chk("sub_eq_cnd_g", cnd, 1'b0);
      step();

      // Backpressure: result held, second request waits
      out_ready = 1'b0;
      drive(1'b1, 2'b00, 64'd4, 64'd6, 1'b0);
      step();
      drive(1'b1, 2'b11, 64'd1, 64'd2, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_ans", out_ans, 64'hA);
         chk("stall_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      step();
      chk("stall_release_ans", out_ans, 64'd3);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      step();

      // Back-to-back at full throughput
      drive(1'b1, 2'b11, 64'hF0, 64'h0F, 1'b0);
      step();
      chk("b2b_xor_ans", out_ans, 64'hFF);
      chk("b2b_xor_valid", out_valid, 1'b1);
      drive(1'b1, 2'b10, 64'hF0, 64'h0F, 1'b0);
      step();
      chk("b2b_and_ans", out_ans, 64'h0);
      chk("b2b_and_valid", out_valid, 1'b1);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      step();
      chk("b2b_drained", out_valid, 1'b0);

      // cc hold without set_cc, then reset in the middle of a stall
      drive(1'b1, 2'b00, MAXP, 64'd1, 1'b1);
      step();
      drive(1'b1, 2'b10, 64'd3, 64'd5, 1'b0);
      step();
      chk("nocc_cc", cc, 3'b011);
      chk("nocc_ans", out_ans, 64'd1);
      out_ready = 1'b0;
      drive(1'b1, 2'b00, 64'd1, 64'd1, 1'b1);
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", out_valid, 1'b0);
      chk("midrst_cc", cc, 3'b100);
      chk("midrst_ans", out_ans, 64'd0);
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      out_ready = 1'b1;
      step();
      chk("postrst_in_ready", in_ready, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [63:0] ra, rb;
         case ($urandom_range(0, 3))
            0: ra = MAXP;
            1: ra = MINN;
            default: ra = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 3))
            0: rb = 64'd1;
            1: rb = ra;
            default: rb = {$urandom, $urandom};
         endcase
         drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), ra, rb,
               1'($urandom_range(0, 1)));
         out_ready = $urandom_range(0, 3) != 0;
         cond_fn   = 3'($urandom_range(0, 7));
         rst       = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      drive(1'b0, 2'b00, 64'd0, 64'd0, 1'b0);
      step();

      // Narrow-width table
      for (int i = 0; i < 8; i++) begin
         n_in_valid = 1'b1;
         n_in_op    = t8[i].op;
         n_in_a     = t8[i].a;
         n_in_b     = t8[i].b;
         @(posedge clk);
         #1;
         chk($sformatf("tbl8_%0d_ans", i), n_out_ans, t8[i].ans);
         chk($sformatf("tbl8_%0d_ovf", i), n_out_overflow, t8[i].ovf);
         chk($sformatf("tbl8_%0d_valid", i), n_out_valid, 1'b1);
      end
      n_in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("tbl8_drained", n_out_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
